// File: rtl/scanning_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : scanning_decoder_if
// Description : Select/strobe bundle between a scanning_decoder and its user.
// Revision    : 1.0 - initial release
// ============================================================================
interface scanning_decoder_if #(
    parameter int N = 3
);
    localparam int c_outs = 2**N;

    logic              enable;
    logic              mode;
    logic [N-1:0]      in;
    logic [c_outs-1:0] out;
    logic [N-1:0]      sel;
    logic              wrap;

    modport master (
        output enable, mode, in,
        input  out, sel, wrap
    );

    modport slave (
        input  enable, mode, in,
        output out, sel, wrap
    );
endinterface
`default_nettype wire

// File: rtl/scanning_decoder.sv
`default_nettype none
// ============================================================================
// Module      : scanning_decoder
// Description : Registered N-to-2^N one-hot decoder with a dwell-timed auto-scan.
// Revision    : 1.0 - initial release
// ============================================================================
module scanning_decoder #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    scanning_decoder_if.slave  bus
);
    localparam int                c_outs      = 2**N;
    localparam int                c_dw        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_dw-1:0]   c_dcnt_last = c_dw'(DWELL - 1);
    localparam logic [N-1:0]      c_idx_last  = N'(c_outs - 1);
    localparam logic [c_outs-1:0] c_hot0      = c_outs'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t            w_state;
    logic [c_outs-1:0] r_out;
    logic [N-1:0]      r_sel;
    logic              r_wrap;
    logic [N-1:0]      r_idx;
    logic [c_dw-1:0]   r_dcnt;
    logic              r_wrap_pend;

    // The operating state is fully determined by the inputs sampled at each edge.
    always_comb begin
        w_state = ST_IDLE;
        if (bus.enable) begin
            w_state = bus.mode ? ST_SCAN : ST_DIRECT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_sel       <= '0;
            r_wrap      <= 1'b0;
            r_idx       <= '0;
            r_dcnt      <= '0;
            r_wrap_pend <= 1'b0;
        end else begin
            case (w_state)
                ST_DIRECT: begin
                    r_out       <= c_hot0 << bus.in;
                    r_sel       <= bus.in;
                    r_wrap      <= 1'b0;
                    r_idx       <= '0;
                    r_dcnt      <= '0;
                    r_wrap_pend <= 1'b0;
                end
                ST_SCAN: begin
                    r_out  <= c_hot0 << r_idx;
                    r_sel  <= r_idx;
                    // Pending flag survives IDLE so a paused wrap still pulses on index 0.
                    r_wrap <= r_wrap_pend;
                    if (r_dcnt == c_dcnt_last) begin
                        r_dcnt      <= '0;
                        r_idx       <= r_idx + N'(1);
                        r_wrap_pend <= (r_idx == c_idx_last);
                    end else begin
                        r_dcnt      <= r_dcnt + c_dw'(1);
                        r_wrap_pend <= 1'b0;
                    end
                end
                default: begin
                    r_out  <= '0;
                    r_wrap <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out  = r_out;
    assign bus.sel  = r_sel;
    assign bus.wrap = r_wrap;
endmodule
`default_nettype wire

// File: tb/tb_scanning_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_scanning_decoder
// Description : Directed bench for scanning_decoder (DWELL=4 and DWELL=1 builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scanning_decoder;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    scanning_decoder_if #(.N(3)) bm ();
    scanning_decoder_if #(.N(3)) b1 ();

    scanning_decoder #(.N(3), .DWELL(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bm)
    );

    scanning_decoder #(.N(3), .DWELL(1)) u_dut_d1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word layout: {wrap, sel[2:0], out[7:0]}
    function automatic logic [11:0] ev(input logic w, input int s, input logic [7:0] o);
        return {w, 3'(s), o};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
        end
    endtask

    task automatic expect_scan(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            chk("scan_hold", {bm.wrap, bm.sel, bm.out}, ev(1'b0, s, 8'h01 << s));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bm.enable   = 1'b1;
        bm.mode     = 1'b1;
        bm.in       = '0;
        b1.enable   = 1'b1;
        b1.mode     = 1'b1;
        b1.in       = '0;

        tick();
        chk("reset_0", {bm.wrap, bm.sel, bm.out}, ev(1'b0, 0, 8'h00));
        chk("reset_d1", {b1.wrap, b1.sel, b1.out}, ev(1'b0, 0, 8'h00));
        tick();
        chk("reset_1", {bm.wrap, bm.sel, bm.out}, ev(1'b0, 0, 8'h00));
        rst = 1'b0;
        tick();
        chk("first_after_reset", {bm.wrap, bm.sel, bm.out}, ev(1'b0, 0, 8'h01));

        bm.mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bm.in = 3'(i);
            tick();
            chk("direct", {bm.wrap, bm.sel, bm.out}, ev(1'b0, i, 8'h01 << i));
        end

        bm.mode = 1'b1;
        for (int e = 1; e <= 42; e++) begin
            tick();
            chk("scan_run", {bm.wrap, bm.sel, bm.out},
                ev(e == 33, ((e - 1) / 4) % 8, 8'h01 << (((e - 1) / 4) % 8)));
        end

        bm.mode = 1'b0;
        bm.in   = 3'd6;
        tick();
        chk("scan_to_direct", {bm.wrap, bm.sel, bm.out}, ev(1'b0, 6, 8'h40));
        bm.mode = 1'b1;
        expect_scan(0, 4);
        expect_scan(1, 4);
        expect_scan(2, 4);
        expect_scan(3, 2);

        bm.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pause", {bm.wrap, bm.sel, bm.out}, ev(1'b0, 3, 8'h00));
        end
        bm.enable = 1'b1;
        expect_scan(3, 2);
        expect_scan(4, 4);
        expect_scan(5, 4);
        expect_scan(6, 4);
        expect_scan(7, 4);

        bm.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pause_at_last", {bm.wrap, bm.sel, bm.out}, ev(1'b0, 7, 8'h00));
        end
        bm.enable = 1'b1;
        tick();
        chk("wrap_after_pause", {bm.wrap, bm.sel, bm.out}, ev(1'b1, 0, 8'h01));
        expect_scan(0, 3);
        expect_scan(1, 4);
        expect_scan(2, 4);
        expect_scan(3, 4);
        expect_scan(4, 4);
        expect_scan(5, 2);

        rst = 1'b1;
        tick();
        chk("reset_mid_scan", {bm.wrap, bm.sel, bm.out}, ev(1'b0, 0, 8'h00));
        chk("reset_mid_d1", {b1.wrap, b1.sel, b1.out}, ev(1'b0, 0, 8'h00));
        rst = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk("restart_scan", {bm.wrap, bm.sel, bm.out},
                ev(1'b0, (k - 1) / 4, 8'h01 << ((k - 1) / 4)));
            chk("dwell1_scan", {b1.wrap, b1.sel, b1.out},
                ev(k == 9 || k == 17, (k - 1) % 8, 8'h01 << ((k - 1) % 8)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
